// File: rtl/sd4_mac_pkg.sv
// Shared types and defaults for the SD4 MAC pipeline sequencer.
package sd4_mac_pkg;

    localparam int PIPE_DEPTH_DEFAULT = 4;
    localparam int LEN_W_DEFAULT      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sd4_mac_vld_tracker.sv
// Valid/last shift pair mirroring the MAC stage registers; bit k describes the stage k+1 output.
module sd4_mac_vld_tracker
    import sd4_mac_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_vld,
    input  logic i_last,
    output logic o_tail_last
);

    logic [DEPTH-1:0] w_vld_sr;
    logic [DEPTH-1:0] w_last_sr;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic r_vld;
            logic r_last;
            logic w_vld_in;
            logic w_last_in;

            if (gi == 0) begin : g_head
                assign w_vld_in  = i_vld;
                assign w_last_in = i_last;
            end else begin : g_body
                assign w_vld_in  = w_vld_sr[gi-1];
                assign w_last_in = w_last_sr[gi-1];
            end

            // Clear wins over shift so an abort never leaves a stale tag behind.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_vld  <= 1'b0;
                    r_last <= 1'b0;
                end else if (i_clr) begin
                    r_vld  <= 1'b0;
                    r_last <= 1'b0;
                end else if (i_en) begin
                    r_vld  <= w_vld_in;
                    r_last <= w_last_in;
                end
            end

            assign w_vld_sr[gi]  = r_vld;
            assign w_last_sr[gi] = r_last;
        end
    endgenerate

    // One stage before the output: the final product lands in the last stage on the next advance.
    assign o_tail_last = w_vld_sr[DEPTH-2] & w_last_sr[DEPTH-2];

endmodule

// File: rtl/sd4_mac_seq_ctrl.sv
// Job sequencer for the SD4 MAC pipe: admits N operand pairs, drains, then holds
// the frozen result until the consumer accepts it.
module sd4_mac_seq_ctrl
    import sd4_mac_pkg::*;
#(
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEFAULT,
    parameter int LEN_W      = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_cfg_len,
    input  logic             i_abort,
    output logic             o_busy,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_issue_vld,
    output logic             o_issue_first,
    output logic             o_issue_last,
    output logic             o_pipe_en,
    output logic             o_res_valid,
    input  logic             i_res_ready
);

    state_t           r_state;
    state_t           w_state_next;
    logic [LEN_W-1:0] r_rem;
    logic             r_first_pend;

    logic w_in_ready;
    logic w_pipe_en;
    logic w_res_valid;
    logic w_busy;
    logic w_issue;
    logic w_rem_one;
    logic w_job_go;
    logic w_kill;
    logic w_trk_clr;
    logic w_tail_last;

    assign w_rem_one = (r_rem == LEN_W'(1));
    assign w_job_go  = (r_state == IDLE) && i_start && (i_cfg_len != '0) && !i_abort;
    assign w_kill    = (r_state != IDLE) && i_abort;
    assign w_issue   = i_in_valid && w_in_ready;
    assign w_trk_clr = w_kill || ((r_state == DONE) && i_res_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:  if (w_job_go) w_state_next = FEED;
            FEED:  if (i_abort) w_state_next = IDLE;
                   else if (w_issue && w_rem_one) w_state_next = DRAIN;
            DRAIN: if (i_abort) w_state_next = IDLE;
                   else if (w_tail_last) w_state_next = DONE;
            DONE:  if (i_abort || i_res_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_pipe_en   = 1'b0;
        w_res_valid = 1'b0;
        w_busy      = (r_state != IDLE);
        unique case (r_state)
            FEED: begin
                w_in_ready = !i_abort;
                w_pipe_en  = 1'b1;
            end
            DRAIN:   w_pipe_en   = 1'b1;
            DONE:    w_res_valid = 1'b1;
            default: ;
        endcase
    end

    // Remaining-product counter; FSM leaves FEED on the rem==1 issue, so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem        <= '0;
            r_first_pend <= 1'b0;
        end else if (w_kill) begin
            r_rem        <= '0;
            r_first_pend <= 1'b0;
        end else if (w_job_go) begin
            r_rem        <= i_cfg_len;
            r_first_pend <= 1'b1;
        end else if (w_issue) begin
            r_rem        <= r_rem - LEN_W'(1);
            r_first_pend <= 1'b0;
        end
    end

    sd4_mac_vld_tracker #(
        .DEPTH (PIPE_DEPTH)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_pipe_en),
        .i_clr       (w_trk_clr),
        .i_vld       (w_issue),
        .i_last      (w_issue && w_rem_one),
        .o_tail_last (w_tail_last)
    );

    assign o_busy        = w_busy;
    assign o_in_ready    = w_in_ready;
    assign o_issue_vld   = w_issue;
    assign o_issue_first = w_issue && r_first_pend;
    assign o_issue_last  = w_issue && w_rem_one;
    assign o_pipe_en     = w_pipe_en;
    assign o_res_valid   = w_res_valid;

endmodule

// File: tb/tb_sd4_mac_seq_ctrl.sv
// Bench for sd4_mac_seq_ctrl: directed vector table, hand-written corner sequences,
// and random traffic checked against a job-level timing model.
module tb_sd4_mac_seq_ctrl;

    localparam int D  = 4;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          res_ready = 1'b0;
    logic          busy, in_ready, issue_vld, issue_first, issue_last, pipe_en, res_valid;

    sd4_mac_seq_ctrl #(.PIPE_DEPTH(D), .LEN_W(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (start),
        .i_cfg_len     (cfg_len),
        .i_abort       (abort),
        .o_busy        (busy),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .o_issue_vld   (issue_vld),
        .o_issue_first (issue_first),
        .o_issue_last  (issue_last),
        .o_pipe_en     (pipe_en),
        .o_res_valid   (res_valid),
        .i_res_ready   (res_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Job-level model: a job is active from start until accepted or aborted;
    // its result is ready D cycles after the cycle of its final issue.
    bit m_active;
    int m_n, m_issued, m_last_t, m_cyc, t0, rv_at;

    typedef struct {
        logic          start;
        logic [LW-1:0] len;
        logic          vin;
        logic          rr;
        logic          ab;
        logic [6:0]    exp;   // {busy,in_ready,issue_vld,first,last,pipe_en,res_valid}
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_n = 0; m_issued = 0; m_last_t = -1; m_cyc = 0; t0 = 0; rv_at = -1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 0; cfg_len = '0; abort = 0; in_valid = 0; res_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic tick();
        bit done, ir, iss;
        @(negedge clk);
        done = m_active && (m_issued == m_n) && (m_cyc - m_last_t >= D);
        ir   = m_active && (m_issued < m_n) && !abort;
        iss  = ir && in_valid;
        chk("busy",        32'(busy),        32'(m_active));
        chk("in_ready",    32'(in_ready),    32'(ir));
        chk("issue_vld",   32'(issue_vld),   32'(iss));
        chk("issue_first", 32'(issue_first), 32'(iss && m_issued == 0));
        chk("issue_last",  32'(issue_last),  32'(iss && m_issued == m_n - 1));
        chk("pipe_en",     32'(pipe_en),     32'(m_active && !done));
        chk("res_valid",   32'(res_valid),   32'(done));
        if (res_valid && m_active && rv_at < 0) rv_at = m_cyc - t0;
        if (m_active && abort) begin
            m_active = 0;
        end else if (done && res_ready) begin
            m_active = 0;
        end else if (!m_active && start && cfg_len != 0) begin
            m_active = 1; m_n = int'(cfg_len); m_issued = 0; m_last_t = -1;
            t0 = m_cyc; rv_at = -1;
        end else if (iss) begin
            m_issued++;
            if (m_issued == m_n) m_last_t = m_cyc;
        end
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int max_cyc);
        int k;
        k = 0;
        while (m_active && k < max_cyc) begin
            tick();
            k++;
        end
        chk("job_ends_in_budget", 32'(m_active), 32'd0);
    endtask

    task automatic begin_job(input int n);
        start = 1; cfg_len = LW'(n);
        tick();
        start = 0; cfg_len = '0;
    endtask

    initial begin
        int held;
        vecs[0] = '{1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 7'b0000000};
        vecs[1] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 7'b1111010};
        vecs[2] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 7'b1110010};
        vecs[3] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 7'b1110110};
        vecs[4] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 7'b1000010};
        vecs[5] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 7'b1000010};
        vecs[6] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 7'b1000010};
        vecs[7] = '{1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 7'b1000001};
        vecs[8] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 7'b0000000};

        do_reset();
        tick();  // reset state: all outputs low

        // N=3 directed vectors; a start in the DONE handshake cycle must be ignored
        for (int r = 0; r < 9; r++) begin
            start = vecs[r].start; cfg_len = vecs[r].len; in_valid = vecs[r].vin;
            res_ready = vecs[r].rr; abort = vecs[r].ab;
            @(negedge clk);
            chk($sformatf("tbl%0d_outs", r),
                {25'd0, busy, in_ready, issue_vld, issue_first, issue_last, pipe_en, res_valid},
                {25'd0, vecs[r].exp});
            @(posedge clk);
            #1;
        end
        $display("directed table: 9 cycles applied");

        // N=4 with a bubble in cycle 2
        do_reset();
        res_ready = 1;
        begin_job(4);
        in_valid = 1; tick();
        in_valid = 0; tick();
        in_valid = 1;
        run_until_idle(30);
        chk("n4_bubble_latency", 32'(rv_at), 32'd9);
        $display("N=4 bubble job: res_valid at cycle %0d", rv_at);

        // N=1, start in cycle 2 while busy
        do_reset();
        res_ready = 1;
        begin_job(1);
        in_valid = 1; tick();
        start = 1; cfg_len = 8'd5; tick();
        start = 0; cfg_len = '0;
        run_until_idle(30);
        chk("n1_latency", 32'(rv_at), 32'd5);
        tick();
        chk("n1_stays_idle", 32'(busy), 32'd0);
        $display("N=1 job: res_valid at cycle %0d", rv_at);

        // Result held 6 cycles with res_ready low
        do_reset();
        in_valid = 1; res_ready = 0;
        begin_job(2);
        for (int k = 0; k < 20 && !res_valid; k++) tick();
        chk("hold_reached_done", 32'(res_valid), 32'd1);
        held = 0;
        for (int k = 0; k < 6; k++) begin
            if (res_valid && !pipe_en) held++;
            tick();
        end
        chk("hold_cycles", 32'(held), 32'd6);
        res_ready = 1; tick();
        chk("hold_idle_after_accept", 32'(busy), 32'd0);
        $display("held result for %0d cycles", held);

        // Abort in DRAIN, then a fresh N=2 job
        do_reset();
        in_valid = 1; res_ready = 1;
        begin_job(5);
        repeat (6) tick();
        abort = 1; tick();
        abort = 0;
        chk("abort_idle_next", 32'(busy), 32'd0);
        repeat (6) tick();
        chk("abort_no_result", 32'(rv_at), 32'hFFFF_FFFF);
        begin_job(2);
        run_until_idle(30);
        chk("post_abort_latency", 32'(rv_at), 32'd6);
        $display("abort in DRAIN then N=2 job: res_valid at cycle %0d", rv_at);

        // Zero-length start is ignored
        do_reset();
        begin_job(0);
        tick();
        chk("len0_not_busy", 32'(busy), 32'd0);
        $display("zero-length start applied");

        // Asynchronous reset mid-FEED
        do_reset();
        in_valid = 1; res_ready = 1;
        begin_job(6);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_outs", {25'd0, busy, in_ready, issue_vld, issue_first, issue_last, pipe_en, res_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid = 0;
        model_reset();
        tick();
        $display("async reset mid-FEED applied");

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom % 4 == 0);
            cfg_len   = ($urandom % 8 == 0) ? 8'd0 :
                        (($urandom % 6 == 0) ? LW'($urandom_range(1, 20)) : LW'($urandom_range(1, 6)));
            in_valid  = ($urandom % 4 != 0);
            res_ready = ($urandom % 3 != 0);
            abort     = start ? 1'b0 : ($urandom % 50 == 0);
            tick();
        end
        $display("random traffic: 3000 cycles applied");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
